// File: rtl/pipelined_dot_mac_if.sv
// pipelined_dot_mac_if: valid/ready stream bundle for the pipelined dot-product MAC.
interface pipelined_dot_mac_if #(
    parameter int W     = 16,
    parameter int N     = 2,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   a;
    logic [N*W-1:0]   b;
    logic [W-1:0]     e;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] y;
    logic             ovf;
    modport master(output in_valid, a, b, e, out_ready, input in_ready, out_valid, y, ovf);
    modport slave(input in_valid, a, b, e, out_ready, output in_ready, out_valid, y, ovf);
endinterface

// File: rtl/pipelined_dot_mac.sv
// pipelined_dot_mac: three-stage signed dot product plus bias, wrap or saturate on output.
module pipelined_dot_mac #(
    parameter int W     = 16,
    parameter int N     = 2,
    parameter int OUT_W = 32,
    parameter int SAT   = 0
) (
    input logic clk,
    input logic rst_n,
    pipelined_dot_mac_if.slave io
);
    localparam int ACC_W = 2 * W + $clog2(N + 1);
    logic                    v1, v2, r1, r2, r3;
    logic signed [2*W-1:0]   p[N];
    logic signed [W-1:0]     e1;
    logic signed [ACC_W-1:0] s2, sum;
    logic [OUT_W-1:0]        y_n;
    logic                    ovf_n;
    assign r3 = ~io.out_valid | io.out_ready;
    assign r2 = ~v2 | r3;
    assign r1 = ~v1 | r2;
    assign io.in_ready = r1;
    always_comb begin
        sum = ACC_W'(e1);
        for (int i = 0; i < N; i++) sum += ACC_W'(p[i]);
    end
    generate
        if (OUT_W >= ACC_W) begin : g_wide
            assign y_n   = OUT_W'(s2);
            assign ovf_n = 1'b0;
        end else begin : g_narrow
            // MAX is the largest OUT_W value at ACC_W; its complement truncates to the minimum
            localparam logic signed [ACC_W-1:0] MAX = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
            logic [OUT_W-1:0] lo;
            logic             wrap;
            assign lo    = s2[OUT_W-1:0];
            assign wrap  = ACC_W'(signed'(lo)) != s2;
            assign ovf_n = wrap;
            assign y_n   = (SAT != 0 && wrap) ? (s2[ACC_W-1] ? OUT_W'(~MAX) : OUT_W'(MAX)) : lo;
        end
    endgenerate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1           <= 1'b0;
            v2           <= 1'b0;
            e1           <= '0;
            s2           <= '0;
            io.out_valid <= 1'b0;
            io.y         <= '0;
            io.ovf       <= 1'b0;
            for (int i = 0; i < N; i++) p[i] <= '0;
        end else begin
            if (r1) v1 <= io.in_valid;
            if (r1 && io.in_valid) begin
                for (int i = 0; i < N; i++)
                    p[i] <= (2*W)'($signed(io.a[i*W +: W])) * (2*W)'($signed(io.b[i*W +: W]));
                e1 <= io.e;
            end
            if (r2) v2 <= v1;
            if (r2 && v1) s2 <= sum;
            if (r3) io.out_valid <= v2;
            if (r3 && v2) begin
                io.y   <= y_n;
                io.ovf <= ovf_n;
            end
        end
    end
endmodule
